// File: rtl/sw_conditioner.sv
// Slide-switch / push-button conditioner: two-flop synchroniser, per-bit
// stability-counter debounce, clean level plus one-cycle rise/fall/any pulses.
module sw_conditioner #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_level,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_any,
  output logic [WIDTH-1:0] dbg_pending
);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             any_q, any_d;
  state_e           state_q [WIDTH];
  state_e           state_d [WIDTH];
  logic [CNT_W-1:0] cnt_q   [WIDTH];
  logic [CNT_W-1:0] cnt_d   [WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      any_q   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      any_q   <= any_d;
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // A change is accepted only after DEBOUNCE_CYCLES consecutive mismatching
  // synchronised samples; any match in between restarts from STABLE.
  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_STABLE: begin
          if (sync2_q[i] != level_q[i]) begin
            state_d[i] = ST_PENDING;
            cnt_d[i]   = CNT_W'(1);
          end else begin
            cnt_d[i] = '0;
          end
        end
        ST_PENDING: begin
          if (sync2_q[i] == level_q[i]) begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            level_d[i] = sync2_q[i];
            rise_d[i]  = sync2_q[i];
            fall_d[i]  = ~sync2_q[i];
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = ST_STABLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
    any_d = |{rise_d, fall_d};
  end

  always_comb begin
    dbg_pending = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dbg_pending[i] = (state_q[i] == ST_PENDING);
    end
  end

  assign sw_level = level_q;
  assign sw_rise  = rise_q;
  assign sw_fall  = fall_q;
  assign sw_any   = any_q;

endmodule

// File: doc/sw_conditioner.md
Name: sw_conditioner

Overview:
- Input-side conditioner for the board slide switches and push-buttons.
- Each raw asynchronous switch line is synchronised into clk, debounced by a per-bit stability counter, and output as a clean level plus single-cycle rise/fall pulses.
- Sits between the FPGA switch pins and the LED test logic. Downstream logic consumes the clean levels, or uses the pulses as set/clear events.

Parameters:
- WIDTH, 4, number of switch lines conditioned.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a change is accepted. This is 10 ms at 100 MHz. Legal range is 2 or more.
- CNT_W, 20, debounce counter width. The integrator must ensure 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- sw_raw  input  WIDTH  raw asynchronous switch pins
- sw_level  output  WIDTH  debounced switch level, registered
- sw_rise  output  WIDTH  one-cycle pulse per bit on an accepted 0->1 change
- sw_fall  output  WIDTH  one-cycle pulse per bit on an accepted 1->0 change
- sw_any  output  1  one-cycle pulse, the OR of all sw_rise and sw_fall bits, registered in the same cycle

Behaviour:
- Reset is synchronous, active-high, on clock clk. While rst=1 at a clk edge, all of the following clear to 0:
  - synchroniser flops
  - counters
  - sw_level, sw_rise, sw_fall, sw_any
- Synchroniser: two flops per bit, sync1 <= sw_raw, then sync2 <= sync1. No logic sits between the two stages.
- Each bit runs an independent two-state FSM with a CNT_W-bit counter.
  - STABLE (the reset state):
    - If sync2 == sw_level, stay and hold cnt=0.
    - If sync2 != sw_level, go to PENDING with cnt=1.
  - PENDING:
    - If sync2 == sw_level (glitch), return to STABLE and set cnt=0. No output change.
    - If sync2 != sw_level and cnt < DEBOUNCE_CYCLES-1, increment cnt.
    - If sync2 != sw_level and cnt == DEBOUNCE_CYCLES-1, accept the change:
      - sw_level[i] <= sync2[i];
      - sw_rise[i] or sw_fall[i] <= 1, whichever matches the direction;
      - cnt <= 0, state <= STABLE.
- Pulses:
  - sw_rise, sw_fall and sw_any are high for exactly one cycle: the cycle in which the new sw_level value is first visible.
  - At all other times they are 0.
- Latency: for a raw change that is steady from before edge 1, the synchroniser captures at edges 1–2. The accepted level and its pulse are visible after edge DEBOUNCE_CYCLES+2.
- Glitch rejection: any raw excursion shorter than DEBOUNCE_CYCLES synchronised cycles produces no output change and no pulse. Each return to the current level restarts the count from zero.
- Bits are fully independent. Simultaneous changes on several bits produce simultaneous pulses, and sw_any is a single pulse.
- Counter never wraps: the maximum reached is DEBOUNCE_CYCLES-1, then it clears.
- Reset mid-operation: a pending count is discarded and sw_level returns to 0.
  - If a switch is held high through reset release, it is treated as a fresh 0->1 change.
  - sw_rise then fires DEBOUNCE_CYCLES+2 cycles after the first edge with rst=0.
- No combinational path from sw_raw to any output.

Test Plan:
- All directed tests use DEBOUNCE_CYCLES=4 and WIDTH=4.
1. Reset: hold rst=1 for 3 cycles with sw_raw=4'hF -> all outputs 0 during reset. After release, sw_level=4'hF, and sw_rise=4'hF plus sw_any=1 for one cycle, visible exactly 6 edges after the first edge with rst=0. Pulses are 0 afterwards.
2. Clean press: sw_raw[0] 0->1 held -> sw_level[0]=1 and sw_rise[0]=1 for one cycle after edge 6. sw_fall stays 0. Releasing gives sw_fall[0]=1 after edge 6 and sw_level[0]=0.
3. Glitch: sw_raw[1] high for 3 cycles, then low -> sw_level[1] stays 0 and no pulses on any output.
4. Bounce: sw_raw[2] toggles 1,0,1,0,1 one cycle each, then holds 1 -> a single sw_rise[2] pulse 6 edges after the final 0->1 transition, and no earlier pulse.
5. Simultaneous: sw_raw 4'h0->4'hA in one cycle -> sw_rise=4'hA in a single cycle, sw_any=1 for one cycle, sw_level=4'hA.
6. Reset mid-count: sw_raw[3]=1, rst asserted when the counter reaches 2 -> outputs cleared. After release, sw_rise[3] fires 6 edges after the first edge with rst=0.
